controle_votacao: RTL and testbench

Day-phase voting sequencer for the werewolf game. After the night phase, the top-level FSM pulses `inicia`; this block walks the living players in index order, accepts one vote per player through the shared button/target inputs, and tallies the votes. It then scans the tally and reports either the eliminated player or a tie/no-decision. It owns the vote counters and the "whose turn" pointer, so the display and input datapath only ever serve one voter at a time.

---
 rtl/controle_votacao_if.sv | 27 ++
 rtl/controle_votacao.sv | 133 +++++++++++++
 tb/tb_controle_votacao.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/controle_votacao_if.sv
// Voting-phase bundle between the game controller (master) and controle_votacao (slave).
interface controle_votacao_if #(parameter int N_JOGADORES = 8);
  localparam int W = $clog2(N_JOGADORES);

  logic                   inicia;
  logic [N_JOGADORES-1:0] vivos;
  logic [W-1:0]           alvo;
  logic                   confirma;
  logic                   abstem;
  logic [W-1:0]           jogador_atual;
  logic                   aguardando;
  logic                   erro_voto;
  logic                   fim;
  logic [W-1:0]           eliminado;
  logic                   empate;
  logic [3:0]             db_estado;

  modport master (
    output inicia, vivos, alvo, confirma, abstem,
    input  jogador_atual, aguardando, erro_voto, fim, eliminado, empate, db_estado
  );

  modport slave (
    input  inicia, vivos, alvo, confirma, abstem,
    output jogador_atual, aguardando, erro_voto, fim, eliminado, empate, db_estado
  );
endinterface

// File: rtl/controle_votacao.sv
// Day-phase voting sequencer: one vote per living player, then a serial tally scan.
// Optional abstention support is built when VOTO_BRANCO_EN is defined.
module controle_votacao #(
  parameter int N_JOGADORES = 8
) (
  input logic clock,
  input logic reset,
  controle_votacao_if.slave bus
);
  localparam int W  = $clog2(N_JOGADORES);
  localparam int TW = $clog2(N_JOGADORES + 1);
  localparam logic [W-1:0] ULTIMO = W'(N_JOGADORES - 1);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    ZERA     = 4'd1,
    BUSCA    = 4'd2,
    ESPERA   = 4'd3,
    REGISTRA = 4'd4,
    PROXIMO  = 4'd5,
    APURA    = 4'd6,
    FIM      = 4'd7
  } estado_t;

  estado_t        estado, prox;
  logic [W-1:0]   ptr, ptr_mais, voto, idx, argmax;
  logic [TW-1:0]  tally [N_JOGADORES];
  logic [TW-1:0]  maximo;
  logic           tie, erro_q, rejeita;
  logic           alvo_ok, vivo_atual, vivo_seguinte, ha_vivo, sem_votos;

  assign ptr_mais      = ptr + W'(1);
  assign vivo_atual    = bus.vivos[ptr];
  assign vivo_seguinte = bus.vivos[ptr_mais];
  assign ha_vivo       = |(bus.vivos >> ptr);
  assign alvo_ok       = (int'(bus.alvo) < N_JOGADORES) ? bus.vivos[bus.alvo] : 1'b0;
  assign sem_votos     = (maximo == '0);

  always_ff @(posedge clock) begin
    if (!reset) estado <= OCIOSO;
    else        estado <= prox;
  end

  // BUSCA and PROXIMO look one index ahead so a living next voter costs no extra cycle.
  always_comb begin
    prox    = estado;
    rejeita = 1'b0;
    case (estado)
      OCIOSO, FIM: if (bus.inicia) prox = ZERA;
      ZERA:        prox = BUSCA;
      BUSCA: begin
        if (vivo_atual)         prox = ESPERA;
        else if (!ha_vivo)      prox = APURA;
        else if (vivo_seguinte) prox = ESPERA;
      end
      ESPERA: begin
        if (bus.confirma) begin
`ifdef VOTO_BRANCO_EN
          if (bus.abstem)      prox = PROXIMO;
          else if (alvo_ok)    prox = REGISTRA;
          else                 rejeita = 1'b1;
`else
          if (alvo_ok)         prox = REGISTRA;
          else                 rejeita = 1'b1;
`endif
        end
      end
      REGISTRA: prox = PROXIMO;
      PROXIMO: begin
        if (ptr == ULTIMO)      prox = APURA;
        else if (vivo_seguinte) prox = ESPERA;
        else                    prox = BUSCA;
      end
      APURA:   if (idx == ULTIMO) prox = FIM;
      default: prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr    <= '0;
      voto   <= '0;
      idx    <= '0;
      maximo <= '0;
      argmax <= '0;
      tie    <= 1'b0;
      erro_q <= 1'b0;
      for (int i = 0; i < N_JOGADORES; i++) tally[i] <= '0;
    end else begin
      erro_q <= rejeita;
      case (estado)
        ZERA: begin
          ptr    <= '0;
          idx    <= '0;
          maximo <= '0;
          argmax <= '0;
          tie    <= 1'b0;
          for (int i = 0; i < N_JOGADORES; i++) tally[i] <= '0;
        end
        BUSCA:    if (!vivo_atual && ha_vivo) ptr <= ptr_mais;
        ESPERA:   if (bus.confirma) voto <= bus.alvo;
        REGISTRA: tally[voto] <= tally[voto] + TW'(1);
        PROXIMO:  if (ptr != ULTIMO) ptr <= ptr_mais;
        APURA: begin
          idx <= idx + W'(1);
          if (tally[idx] > maximo) begin
            maximo <= tally[idx];
            argmax <= idx;
            tie    <= 1'b0;
          end else if (tally[idx] == maximo && maximo != '0) begin
            tie <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.aguardando = (estado == ESPERA);
    bus.fim        = (estado == FIM);
    bus.db_estado  = estado;
    bus.empate     = 1'b0;
    bus.eliminado  = '0;
    if (estado == FIM) begin
      bus.empate = tie | sem_votos;
      if (!(tie | sem_votos)) bus.eliminado = argmax;
    end
  end

  assign bus.jogador_atual = ptr;
  assign bus.erro_voto     = erro_q;
endmodule

// File: tb/tb_controle_votacao.sv
// Directed bench for controle_votacao: an 8-player and a 6-player instance share clock and reset.
module tb_controle_votacao;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  controle_votacao_if #(.N_JOGADORES(8)) b8 ();
  controle_votacao_if #(.N_JOGADORES(6)) b6 ();

  controle_votacao #(.N_JOGADORES(8)) dut8 (.clock(clock), .reset(reset), .bus(b8));
  controle_votacao #(.N_JOGADORES(6)) dut6 (.clock(clock), .reset(reset), .bus(b6));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;
  int lat   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start8();
    b8.inicia = 1'b1;
    tick();
    b8.inicia = 1'b0;
    t0 = cyc;
  endtask

  task automatic start6();
    b6.inicia = 1'b1;
    tick();
    b6.inicia = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_ag8(output int l);
    int n = 0;
    while (!b8.aguardando && n < 60) begin tick(); n++; end
    if (!b8.aguardando) chk("aguardando8_timeout", 32'(b8.aguardando), 32'd1);
    l = cyc - t0;
  endtask

  task automatic wait_ag6();
    int n = 0;
    while (!b6.aguardando && n < 60) begin tick(); n++; end
    if (!b6.aguardando) chk("aguardando6_timeout", 32'(b6.aguardando), 32'd1);
  endtask

  task automatic vote8(input int a, input bit ab, input int jog);
    int l;
    wait_ag8(l);
    chk("jogador_atual8", 32'(b8.jogador_atual), jog);
    b8.alvo     = 3'(a);
    b8.abstem   = ab;
    b8.confirma = 1'b1;
    tick();
    b8.confirma = 1'b0;
    b8.abstem   = 1'b0;
  endtask

  task automatic vote6(input int a, input int jog);
    wait_ag6();
    chk("jogador_atual6", 32'(b6.jogador_atual), jog);
    b6.alvo     = 3'(a);
    b6.confirma = 1'b1;
    tick();
    b6.confirma = 1'b0;
  endtask

  task automatic wait_fim8(output int l);
    int n = 0;
    while (!b8.fim && n < 300) begin tick(); n++; end
    if (!b8.fim) chk("fim8_timeout", 32'(b8.fim), 32'd1);
    l = cyc - t0;
  endtask

  task automatic wait_fim6(output int l);
    int n = 0;
    while (!b6.fim && n < 300) begin tick(); n++; end
    if (!b6.fim) chk("fim6_timeout", 32'(b6.fim), 32'd1);
    l = cyc - t0;
  endtask

  initial begin
    int v1 [8] = '{3, 3, 3, 1, 1, 2, 5, 3};
    int n;
    b8.inicia = 0; b8.vivos = '0; b8.alvo = '0; b8.confirma = 0; b8.abstem = 0;
    b6.inicia = 0; b6.vivos = '0; b6.alvo = '0; b6.confirma = 0; b6.abstem = 0;

    // reset state
    tick(); tick();
    chk("rst_db_estado", 32'(b8.db_estado), 32'd0);
    chk("rst_fim", 32'(b8.fim), 32'd0);
    chk("rst_aguardando", 32'(b8.aguardando), 32'd0);
    chk("rst_erro", 32'(b8.erro_voto), 32'd0);
    chk("rst_empate", 32'(b8.empate), 32'd0);
    chk("rst_eliminado", 32'(b8.eliminado), 32'd0);
    chk("rst_jogador", 32'(b8.jogador_atual), 32'd0);
    reset = 1'b1;
    tick();

    // all alive, votes 3,3,3,1,1,2,5,3
    b8.vivos = 8'hFF;
    start8();
    wait_ag8(lat);
    chk("lat_primeiro_voto", lat, 32'd2);
    for (int i = 0; i < 8; i++) vote8(v1[i], 1'b0, i);
    wait_fim8(lat);
    chk("lat_fim_ff", lat, 32'd34);
    chk("ff_eliminado", 32'(b8.eliminado), 32'd3);
    chk("ff_empate", 32'(b8.empate), 32'd0);

    // sparse alive mask 1010_0101
    b8.vivos = 8'b1010_0101;
    start8();
    wait_ag8(lat);
    chk("a5_jogador0", 32'(b8.jogador_atual), 32'd0);
    b8.inicia = 1'b1;
    tick();
    b8.inicia = 1'b0;
    chk("inicia_ignorado", 32'(b8.db_estado), 32'd3);
    b8.alvo = 3'd1; b8.confirma = 1'b1;
    tick();
    b8.confirma = 1'b0;
    chk("a5_erro_pulso", 32'(b8.erro_voto), 32'd1);
    chk("a5_fica_espera", 32'(b8.db_estado), 32'd3);
    tick();
    chk("a5_erro_cai", 32'(b8.erro_voto), 32'd0);
    vote8(0, 1'b0, 0);
    vote8(2, 1'b0, 2);
    vote8(2, 1'b0, 5);
    vote8(0, 1'b0, 7);
    wait_fim8(lat);
    chk("a5_empate", 32'(b8.empate), 32'd1);
    chk("a5_eliminado", 32'(b8.eliminado), 32'd0);

    // abstem with alvo=0 on every vote
    b8.vivos = 8'hFF;
    start8();
    for (int i = 0; i < 8; i++) vote8(0, 1'b1, i);
    wait_fim8(lat);
`ifdef VOTO_BRANCO_EN
    chk("branco_empate", 32'(b8.empate), 32'd1);
    chk("branco_eliminado", 32'(b8.eliminado), 32'd0);
`else
    chk("sem_branco_empate", 32'(b8.empate), 32'd0);
    chk("sem_branco_eliminado", 32'(b8.eliminado), 32'd0);
`endif

    // N=6: out-of-range target rejected, then votes 4,2,2,4,4,1
    b6.vivos = 6'h3F;
    start6();
    wait_ag6();
    b6.alvo = 3'd7; b6.confirma = 1'b1;
    tick();
    b6.confirma = 1'b0;
    chk("n6_erro_pulso", 32'(b6.erro_voto), 32'd1);
    chk("n6_fica_espera", 32'(b6.db_estado), 32'd3);
    b6.alvo = 3'd4; b6.confirma = 1'b1;
    tick();
    b6.confirma = 1'b0;
    chk("n6_aceita_4", 32'(b6.db_estado), 32'd4);
    vote6(2, 1); vote6(2, 2); vote6(4, 3); vote6(4, 4); vote6(1, 5);
    wait_fim6(lat);
    chk("n6_eliminado", 32'(b6.eliminado), 32'd4);
    chk("n6_empate", 32'(b6.empate), 32'd0);

    // nobody alive: ZERA, BUSCA, N cycles of APURA
    b6.vivos = '0;
    start6();
    wait_fim6(lat);
    chk("n6_lat_mortos", lat, 32'd8);
    chk("n6_mortos_empate", 32'(b6.empate), 32'd1);
    b8.vivos = '0;
    start8();
    wait_fim8(lat);
    chk("n8_lat_mortos", lat, 32'd10);
    chk("n8_mortos_empate", 32'(b8.empate), 32'd1);

    // reset in the middle of APURA, then everyone votes for 6
    b8.vivos = 8'hFF;
    start8();
    for (int i = 0; i < 8; i++) vote8(2, 1'b0, i);
    n = 0;
    while (b8.db_estado != 4'd6 && n < 20) begin tick(); n++; end
    chk("chega_apura", 32'(b8.db_estado), 32'd6);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("rst_apura_estado", 32'(b8.db_estado), 32'd0);
    chk("rst_apura_jogador", 32'(b8.jogador_atual), 32'd0);
    chk("rst_apura_fim", 32'(b8.fim), 32'd0);
    start8();
    for (int i = 0; i < 8; i++) vote8(6, 1'b0, i);
    wait_fim8(lat);
    chk("pos_rst_eliminado", 32'(b8.eliminado), 32'd6);
    chk("pos_rst_empate", 32'(b8.empate), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
